// File: rtl/la_andn_pipe.sv
// la_andn_pipe: pipelined N-input masked AND/NAND reduction with a radix-K tree
// and valid/ready flow control. Each tree level is one pipeline stage.
module la_andn_pipe #(
    parameter int    N      = 16,
    parameter int    K      = 4,
    parameter int    INVERT = 0,
    parameter string PROP   = "DEFAULT"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         z
);

    // Number of tree levels needed to fold N bits down to one; at least one.
    function automatic int calc_stages(input int n, input int k);
        int s;
        int w;
        s = 0;
        w = n;
        while (w > 1) begin
            w = (w + k - 1) / k;
            s = s + 1;
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Width of the partial-result vector held by a given stage.
    function automatic int calc_width(input int n, input int k, input int stage);
        int w;
        w = n;
        for (int j = 0; j <= stage; j++) begin
            w = (w + k - 1) / k;
        end
        return w;
    endfunction

    localparam int STAGES = calc_stages(N, K);

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] vsrc;

    // Ready ripples back from the output: a stage can load if it is empty
    // or if its own contents are moving on this cycle.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = ~vld_p[i] | chain;
            rdy[i] = chain;
        end
    end

    // Valid feeding each stage: the input port for stage 0, else the stage before.
    always_comb begin
        vsrc    = '0;
        vsrc[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            vsrc[i] = vld_p[i-1];
        end
    end

    // Valid bits advance whenever the stage is ready; bubbles move too.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld_p[i] <= vsrc[i];
                end
            end
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int WI = calc_width(N, K, i);
        localparam int WP = (i == 0) ? N : calc_width(N, K, i - 1);

        logic [WP-1:0]   src;
        logic [WI*K-1:0] src_pad;
        logic [WI-1:0]   din;
        logic [WI-1:0]   part_p;

        if (i == 0) begin : g_first
            // Masked-off bits are forced to 1 so they cannot pull the AND low.
            assign src = a | ~mask;
        end else begin : g_next
            assign src = g_stage[i-1].part_p;
        end

        // Group-of-K AND; the ragged last group is padded with ones.
        // The NAND option only touches the final stage's input.
        always_comb begin
            src_pad           = '1;
            src_pad[WP-1:0]   = src;
            din               = '0;
            for (int j = 0; j < WI; j++) begin
                din[j] = (&src_pad[j*K +: K]) ^ ((i == STAGES - 1) && (INVERT != 0));
            end
        end

        // Partial results load only when a valid word arrives, so bubbles
        // leave the data registers untouched.
        always_ff @(posedge clk) begin
            if (reset) begin
                part_p <= '0;
            end else if (rdy[i] && vsrc[i]) begin
                part_p <= din;
            end
        end
    end

    assign in_ready  = rdy[0] & ~reset;
    assign out_valid = vld_p[STAGES-1];
    assign z         = g_stage[STAGES-1].part_p[0];

endmodule

// File: tb/tb_la_andn_pipe.sv
// tb_la_andn_pipe: scoreboard bench for la_andn_pipe driving three geometries
// (16/4 AND, 10/3 AND, 1-bit NAND) with directed and random traffic.
module tb_la_andn_pipe;

    typedef struct {
        logic z;
        int   cyc;
    } exp_t;

    localparam int NN  [3] = '{16, 10, 1};
    localparam int SS  [3] = '{2, 3, 1};
    localparam int INV [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_v [3];
    logic [15:0] m_v [3];
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  zz;
    logic [2:0]  lat_chk;
    logic [2:0]  held;
    logic [2:0]  held_z;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    la_andn_pipe #(.N(16), .K(4), .INVERT(0), .PROP("DEFAULT")) u_dut0 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_v[0]), .mask(m_v[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .z(zz[0])
    );

    la_andn_pipe #(.N(10), .K(3), .INVERT(0)) u_dut1 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_v[1][9:0]), .mask(m_v[1][9:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .z(zz[1])
    );

    la_andn_pipe #(.N(1), .K(2), .INVERT(1)) u_dut2 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_v[2][0:0]), .mask(m_v[2][0:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .z(zz[2])
    );

    // Reference: the result is 1 when no participating bit is zero, then
    // optionally inverted.
    function automatic logic model(input int k, input logic [15:0] av, input logic [15:0] mv);
        int   zeros;
        logic r;
        zeros = 0;
        for (int b = 0; b < NN[k]; b++) begin
            if (mv[b] && !av[b]) zeros++;
        end
        r = (zeros == 0);
        if (INV[k] != 0) r = !r;
        return r;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d]: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks that a
    // stalled output holds its value.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                held[k] = 1'b0;
            end else begin
                if (held[k]) begin
                    check("hold_valid", k, 32'(ov[k]), 32'd1);
                    check("hold_z", k, 32'(zz[k]), 32'(held_z[k]));
                end
                if (ov[k] && ordy[k]) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output [dut%0d]: got z=%0b, expected no output (cycle %0d)", k, zz[k], cyc);
                    end else begin
                        qpop(k, e);
                        check("z", k, 32'(zz[k]), 32'(e.z));
                        if (lat_chk[k]) check("latency", k, 32'(cyc - e.cyc), 32'(SS[k]));
                    end
                end
                held[k]   = ov[k] && !ordy[k];
                held_z[k] = zz[k];
            end
        end
    end

    // Offer one word; push its expected result when the DUT takes it.
    task automatic send(input int k, input logic [15:0] av, input logic [15:0] mv, output int waits);
        exp_t e;
        bit   done;
        done     = 1'b0;
        waits    = 0;
        a_v[k]   = av;
        m_v[k]   = mv;
        iv[k]    = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (ir[k]) begin
                e.z   = model(k, av, mv);
                e.cyc = cyc;
                qpush(k, e);
                if (k == 0) accepted++;
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        iv[k] = 1'b0;
        if (!done) check("send_timeout", k, 32'(done), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("in_ready_during_reset", k, 32'(ir[k]), 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_out_valid", k, 32'(ov[k]), 32'd0);
            check("reset_z", k, 32'(zz[k]), 32'd0);
            check("reset_in_ready", k, 32'(ir[k]), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (qsize(0) + qsize(1) + qsize(2)) != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("drained", k, 32'(qsize(k)), 32'd0);
    endtask

    task automatic rand_run(input int k, input int ncyc);
        exp_t        e;
        logic [31:0] r;
        for (int c = 0; c < ncyc; c++) begin
            ordy[k] = ($urandom_range(0, 3) != 0);
            iv[k]   = ($urandom_range(0, 9) < 7);
            r       = ~($urandom() & $urandom() & $urandom());
            a_v[k]  = r[15:0];
            r       = $urandom();
            m_v[k]  = r[15:0];
            @(negedge clk);
            if (iv[k] && ir[k]) begin
                e.z   = model(k, a_v[k], m_v[k]);
                e.cyc = cyc;
                qpush(k, e);
            end
            @(posedge clk);
            #1;
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          wt;
        logic [15:0] av;
        logic [15:0] bp_a [5];
        bp_a = '{16'hFFFF, 16'hEFFF, 16'hFFFF, 16'hFFFF, 16'hFFDF};

        iv      = '0;
        ordy    = '1;
        lat_chk = '0;
        held    = '0;
        held_z  = '0;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0;
            m_v[k] = '0;
        end

        @(posedge clk);
        #1;
        do_reset(2);

        // Latency and back-to-back throughput on the 16-bit instance.
        lat_chk[0] = 1'b1;
        send(0, 16'hFFFF, 16'hFFFF, wt);
        check("first_accept_wait", 0, 32'(wt), 32'd0);
        send(0, 16'hFFFE, 16'hFFFF, wt);
        check("throughput_wait", 0, 32'(wt), 32'd0);
        // Masking.
        send(0, 16'h00FF, 16'h00FF, wt);
        send(0, 16'h00FF, 16'h01FF, wt);
        send(0, 16'h00FF, 16'h0000, wt);
        drain();

        // Backpressure: output stalled, pipeline fills after two words.
        lat_chk[0] = 1'b0;
        ordy[0]    = 1'b0;
        accepted   = 0;
        fork
            begin
                for (int w = 0; w < 5; w++) send(0, bp_a[w], 16'hFFFF, wt);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_accepts", 0, 32'(accepted), 32'd2);
                check("bp_in_ready", 0, 32'(ir[0]), 32'd0);
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        drain();

        // Reset with two words in flight: neither may ever appear.
        ordy[0] = 1'b0;
        send(0, 16'hFFFF, 16'hFFFF, wt);
        send(0, 16'h0000, 16'hFFFF, wt);
        do_reset(1);
        ordy[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("post_reset_idle", 0, 32'(ov[0]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Odd geometry: single-zero sweep then all ones.
        lat_chk[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            av = ~(16'(1) << i) & 16'h03FF;
            send(1, av, 16'h03FF, wt);
        end
        send(1, 16'h03FF, 16'h03FF, wt);
        drain();

        // One-bit NAND.
        lat_chk[2] = 1'b1;
        send(2, 16'h0001, 16'h0001, wt);
        send(2, 16'h0000, 16'h0001, wt);
        send(2, 16'h0000, 16'h0000, wt);
        send(2, 16'h0001, 16'h0000, wt);
        drain();

        // Random traffic on all three instances at once.
        lat_chk = '0;
        fork
            rand_run(0, 10000);
            rand_run(1, 10000);
            rand_run(2, 10000);
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
